// File: rtl/f_div_seq_if.sv
// Request/response bundle for the sequential float32 divider.
// The sequencer drives the master side; the divider implements the slave side.
interface f_div_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rounding;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic [4:0]  flags;

    modport master (
        output start, a, b, rounding,
        input  busy, done, y, flags
    );

    modport slave (
        input  start, a, b, rounding,
        output busy, done, y, flags
    );
endinterface

// File: rtl/f_div_seq.sv
// Sequential IEEE-754 single-precision divider, radix-2 restoring, one quotient
// bit per cycle; flags ordered NV DZ OF UF NX like the F-unit multiplier.
module f_div_seq #(
    parameter int QBITS = 26
) (
    input  logic     clk,
    input  logic     reset,
    f_div_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RND  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [4:0]         cnt_r;
    logic [25:0]        q_r;
    logic [24:0]        r_r;
    logic [23:0]        mb_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [2:0]         rm_r;
    logic [31:0]        res_y_r;
    logic [4:0]         res_flags_r;
    logic [31:0]        y_r;
    logic [4:0]         flags_r;
    logic               busy_r;
    logic               done_r;

    logic               start_ok_s;
    logic               sign_in_s;
    logic signed [9:0]  e0_s;
    logic               a_zero_s, a_inf_s, a_nan_s, a_snan_s;
    logic               b_zero_s, b_inf_s, b_nan_s, b_snan_s;
    logic               spec_s;
    logic [31:0]        spec_y_s;
    logic [4:0]         spec_flags_s;
    logic               ge_s;
    logic [24:0]        r_sub_s;
    logic [23:0]        sig_s;
    logic               g_s, st_s, inc_s, nx_s, sat_s;
    logic signed [9:0]  en_s, ef_s;
    logic [24:0]        sum_s;
    logic [23:0]        sigf_s;
    logic [31:0]        rnd_y_s;
    logic [4:0]         rnd_flags_s;
    logic               busy_nxt_s, done_nxt_s;
    logic [31:0]        y_nxt_s;
    logic [4:0]         flags_nxt_s;

    assign start_ok_s = (state_r == IDLE) & bus.start;
    assign sign_in_s  = bus.a[31] ^ bus.b[31];
    assign e0_s       = $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + 10'sd127;

    // Operand classification on the live inputs; subnormals count as zero.
    always_comb begin
        a_zero_s = (bus.a[30:23] == 8'h00);
        a_inf_s  = (bus.a[30:23] == 8'hFF) & (bus.a[22:0] == 23'h0);
        a_nan_s  = (bus.a[30:23] == 8'hFF) & (bus.a[22:0] != 23'h0);
        a_snan_s = a_nan_s & ~bus.a[22];
        b_zero_s = (bus.b[30:23] == 8'h00);
        b_inf_s  = (bus.b[30:23] == 8'hFF) & (bus.b[22:0] == 23'h0);
        b_nan_s  = (bus.b[30:23] == 8'hFF) & (bus.b[22:0] != 23'h0);
        b_snan_s = b_nan_s & ~bus.b[22];
    end

    // Special-case result; Inf/0 falls under Inf/finite and raises no DZ.
    always_comb begin
        spec_s       = 1'b1;
        spec_y_s     = 32'h0000_0000;
        spec_flags_s = 5'b00000;
        if (a_nan_s | b_nan_s) begin
            spec_y_s     = 32'h7FC0_0000;
            spec_flags_s = {a_snan_s | b_snan_s, 4'b0000};
        end else if ((a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
            spec_y_s     = 32'h7FC0_0000;
            spec_flags_s = 5'b10000;
        end else if (a_inf_s) begin
            spec_y_s     = {sign_in_s, 8'hFF, 23'h0};
        end else if (b_zero_s) begin
            spec_y_s     = {sign_in_s, 8'hFF, 23'h0};
            spec_flags_s = 5'b01000;
        end else if (b_inf_s | a_zero_s) begin
            spec_y_s     = {sign_in_s, 31'h0};
        end else begin
            spec_s       = 1'b0;
        end
    end

    // One restoring step: trial subtract, then shift the partial remainder.
    always_comb begin
        ge_s = (r_r >= {1'b0, mb_r});
        if (ge_s) begin
            r_sub_s = r_r - {1'b0, mb_r};
        end else begin
            r_sub_s = r_r;
        end
    end

    // Normalization, rounding and range check of the finished quotient.
    always_comb begin
        if (q_r[25]) begin
            sig_s = q_r[25:2];
            g_s   = q_r[1];
            st_s  = q_r[0] | (|r_r);
            en_s  = exp_r;
        end else begin
            sig_s = q_r[24:1];
            g_s   = q_r[0];
            st_s  = |r_r;
            en_s  = exp_r - 10'sd1;
        end
        case (rm_r)
            3'd1:    inc_s = 1'b0;
            3'd2:    inc_s = sign_r & (g_s | st_s);
            3'd3:    inc_s = ~sign_r & (g_s | st_s);
            3'd4:    inc_s = g_s;
            default: inc_s = g_s & (st_s | sig_s[0]);
        endcase
        sum_s = {1'b0, sig_s} + {24'h000000, inc_s};
        if (sum_s[24]) begin
            sigf_s = 24'h800000;
            ef_s   = en_s + 10'sd1;
        end else begin
            sigf_s = sum_s[23:0];
            ef_s   = en_s;
        end
        nx_s  = g_s | st_s;
        sat_s = (rm_r == 3'd1) | ((rm_r == 3'd2) & ~sign_r) | ((rm_r == 3'd3) & sign_r);
        if (ef_s >= 10'sd255) begin
            rnd_y_s     = sat_s ? {sign_r, 31'h7F7F_FFFF} : {sign_r, 31'h7F80_0000};
            rnd_flags_s = 5'b00101;
        end else if (ef_s <= 10'sd0) begin
            rnd_y_s     = {sign_r, 31'h0};
            rnd_flags_s = 5'b00011;
        end else begin
            rnd_y_s     = {sign_r, ef_s[7:0], sigf_s[22:0]};
            rnd_flags_s = {4'b0000, nx_s};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s & spec_s) begin
                    state_nxt_s = FIN;
                end else if (start_ok_s) begin
                    state_nxt_s = DIV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == 5'(QBITS - 1)) begin
                    state_nxt_s = RND;
                end else begin
                    state_nxt_s = DIV;
                end
            end
            RND:     state_nxt_s = FIN;
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic; values are registered below.
    always_comb begin
        busy_nxt_s = (state_nxt_s != IDLE);
        done_nxt_s = (state_r == FIN);
        if (state_r == FIN) begin
            y_nxt_s     = res_y_r;
            flags_nxt_s = res_flags_r;
        end else begin
            y_nxt_s     = y_r;
            flags_nxt_s = flags_r;
        end
    end

    // Datapath: operand capture, iteration and pending-result staging.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= 5'd0;
            q_r         <= 26'h0;
            r_r         <= 25'h0;
            mb_r        <= 24'h0;
            sign_r      <= 1'b0;
            exp_r       <= 10'sd0;
            rm_r        <= 3'd0;
            res_y_r     <= 32'h0;
            res_flags_r <= 5'b00000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        cnt_r       <= 5'd0;
                        q_r         <= 26'h0;
                        r_r         <= {2'b01, bus.a[22:0]};
                        mb_r        <= {1'b1, bus.b[22:0]};
                        sign_r      <= sign_in_s;
                        exp_r       <= e0_s;
                        rm_r        <= bus.rounding;
                        res_y_r     <= spec_y_s;
                        res_flags_r <= spec_flags_s;
                    end
                end
                DIV: begin
                    q_r   <= {q_r[24:0], ge_s};
                    r_r   <= {r_sub_s[23:0], 1'b0};
                    cnt_r <= cnt_r + 5'd1;
                end
                RND: begin
                    res_y_r     <= rnd_y_s;
                    res_flags_r <= rnd_flags_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            y_r     <= 32'h0;
            flags_r <= 5'b00000;
        end else begin
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            y_r     <= y_nxt_s;
            flags_r <= flags_nxt_s;
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.y     = y_r;
    assign bus.flags = flags_r;
endmodule

// File: tb/tb_f_div_seq.sv
// Self-checking bench for f_div_seq: directed cases plus random operands
// compared against an integer-arithmetic reference of the float32 divide.
module tb_f_div_seq;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;
    int   ck;

    f_div_seq_if bus ();

    f_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: quotient bits from a single integer divide, then the rounding rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                                  output logic [31:0] y, output logic [4:0] f, output int lat);
        int ea, eb, e;
        logic s, an, bn, ai, bi, az, bz, g, st, inc, sat;
        longint unsigned ma, mb, num, q, rem, sig;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        an = (ea == 255) && (a[22:0] != 23'h0);
        bn = (eb == 255) && (b[22:0] != 23'h0);
        ai = (ea == 255) && (a[22:0] == 23'h0);
        bi = (eb == 255) && (b[22:0] == 23'h0);
        az = (ea == 0);
        bz = (eb == 0);
        lat = 1;
        f = 5'b00000;
        y = 32'h0;
        if (an || bn) begin
            y = 32'h7FC00000;
            f = {(an && !a[22]) || (bn && !b[22]), 4'b0000};
        end else if ((az && bz) || (ai && bi)) begin
            y = 32'h7FC00000;
            f = 5'b10000;
        end else if (ai) begin
            y = {s, 31'h7F800000};
        end else if (bz) begin
            y = {s, 31'h7F800000};
            f = 5'b01000;
        end else if (bi || az) begin
            y = {s, 31'h0};
        end else begin
            lat = 28;
            ma  = 64'(a[22:0]) | 64'h800000;
            mb  = 64'(b[22:0]) | 64'h800000;
            num = ma << 25;
            q   = num / mb;
            rem = num % mb;
            e   = ea - eb + 127;
            if (q[25]) begin
                sig = q >> 2;
                g   = q[1];
                st  = q[0] | (rem != 64'h0);
            end else begin
                sig = (q >> 1) & 64'hFFFFFF;
                g   = q[0];
                st  = (rem != 64'h0);
                e   = e - 1;
            end
            case (rm)
                3'd1:    inc = 1'b0;
                3'd2:    inc = s & (g | st);
                3'd3:    inc = !s & (g | st);
                3'd4:    inc = g;
                default: inc = g & (st | sig[0]);
            endcase
            sig = sig + 64'(inc);
            if (sig == 64'h1000000) begin
                sig = 64'h800000;
                e   = e + 1;
            end
            sat = (rm == 3'd1) || (rm == 3'd2 && !s) || (rm == 3'd3 && s);
            if (e >= 255) begin
                y = sat ? {s, 31'h7F7FFFFF} : {s, 31'h7F800000};
                f = 5'b00101;
            end else if (e <= 0) begin
                y = {s, 31'h0};
                f = 5'b00011;
            end else begin
                y = {s, 8'(e), 23'(sig)};
                f = {4'b0000, g | st};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_f();
        int sel;
        logic [7:0] e;
        logic [22:0] fr;
        sel = int'($urandom_range(0, 19));
        fr  = 23'($urandom);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else if (sel == 2) begin
            e  = 8'hFF;
            fr = 23'h0;
        end else if (sel < 6) e = 8'($urandom_range(1, 254));
        else if (sel < 8) begin
            e  = 8'($urandom_range(100, 154));
            fr = {fr[22:16], 16'h0};
        end else e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, fr};
    endfunction

    // Called at a negedge while the divider is idle; returns one negedge after acceptance.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.rounding = rm;
        @(negedge clk);
        ck = cyc;
        bus.start    = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.rounding = 3'($urandom);
    endtask

    task automatic wait_done(input string tag, output logic [31:0] y, output logic [4:0] f, output int lat);
        int n;
        logic busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, {31'h0, bus.done}, 32'h1);
        chk({tag, "_busy_held"}, {31'h0, busy_ok}, 32'h1);
        chk({tag, "_busy_clear"}, {31'h0, bus.busy}, 32'h0);
        y   = bus.y;
        f   = bus.flags;
        lat = cyc - ck;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input logic [31:0] ey, input logic [4:0] ef, input int elat);
        logic [31:0] y;
        logic [4:0]  f;
        int lat;
        start_op(a, b, rm);
        wait_done(tag, y, f, lat);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_flags"}, {27'h0, f}, {27'h0, ef});
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        logic [31:0] ra, rb, ey, y;
        logic [4:0]  ef, f;
        logic [2:0]  rm;
        int elat, lat;
        logic seen;
        errors = 0;
        checks = 0;
        cyc = 0;
        ck = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.rounding = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        chk("reset_y", bus.y, 32'h0);
        chk("reset_flags", {27'h0, bus.flags}, 32'h0);

        do_op("basic", 32'h40400000, 32'h40000000, 3'd0, 32'h3FC00000, 5'b00000, 28);
        do_op("third_rne", 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001, 28);
        do_op("third_rtz", 32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001, 28);
        do_op("third_rup", 32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00001, 28);
        do_op("third_rdn_neg", 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00001, 28);
        do_op("div_zero", 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b01000, 1);
        do_op("zero_zero", 32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 1);
        do_op("inf_inf", 32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b10000, 1);
        do_op("snan", 32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, 1);
        do_op("qnan", 32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000, 1);
        do_op("inf_zero", 32'hFF800000, 32'h00000000, 3'd0, 32'hFF800000, 5'b00000, 1);
        do_op("ovf_rne", 32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 5'b00101, 28);
        do_op("ovf_rtz", 32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 5'b00101, 28);
        do_op("ovf_rup_neg", 32'hFF000000, 32'h3E800000, 3'd3, 32'hFF7FFFFF, 5'b00101, 28);
        do_op("unf", 32'h00800000, 32'h42000000, 3'd0, 32'h00000000, 5'b00011, 28);

        // Starts while busy must not disturb the operation in flight.
        @(negedge clk);
        start_op(32'h3F800000, 32'h40400000, 3'd0);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'h40400000;
        bus.b = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignored", y, f, lat);
        chk("ignored_y", y, 32'h3EAAAAAB);
        chk("ignored_flags", {27'h0, f}, 32'h1);
        chk("ignored_lat", 32'(lat), 32'd28);

        // Reset ten edges after acceptance aborts the divide.
        start_op(32'h40400000, 32'h40000000, 3'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'h0, bus.busy}, 32'h0);
        chk("abort_done", {31'h0, bus.done}, 32'h0);
        chk("abort_y", bus.y, 32'h0);
        chk("abort_flags", {27'h0, bus.flags}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", {31'h0, seen}, 32'h0);

        // Random operands, mostly issued back-to-back in the done cycle.
        for (int i = 0; i < 60; i++) begin
            ra = rnd_f();
            rb = rnd_f();
            rm = 3'($urandom_range(0, 7));
            model(ra, rb, rm, ey, ef, elat);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            do_op($sformatf("rnd%0d_%h_%h_%0d", i, ra, rb, rm), ra, rb, rm, ey, ef, elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
